// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage. A shift-add multiplier and a
// restoring divider share one control FSM. Every operation takes WIDTH CALC
// cycles plus one FIX cycle, so latency does not depend on operands.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic [2:0]       i_Op,
  input  logic [WIDTH-1:0] i_Op1,
  input  logic [WIDTH-1:0] i_Op2,
  input  logic             i_Flush,
  output logic             o_Busy,
  output logic             o_Stall,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MULH  = 3'b001;
  localparam logic [2:0] OP_MULHU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_REM   = 3'b110;
  localparam logic [2:0] OP_REMU  = 3'b111;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // Magnitude of a two's-complement word; the most negative value maps to
  // itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     opnd_q;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   prod_q;     // product accumulator, multiplier in low half
  logic [WIDTH:0]       rem_q;      // partial remainder
  logic [WIDTH-1:0]     quo_q;      // dividend shifting out, quotient shifting in
  logic                 res_neg_q;  // negate product high word / quotient in FIX
  logic                 rem_neg_q;  // negate remainder in FIX
  logic [WIDTH-1:0]     result_q;

  logic                 start_ok;
  logic                 signed_op;
  logic                 div_op;
  logic [WIDTH-1:0]     opa, opb;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   prod_step;
  logic [WIDTH+1:0]     div_sh, div_trial;
  logic [WIDTH:0]       rem_step;
  logic [WIDTH-1:0]     quo_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     fix_result;

  // Operand conditioning and one iteration of the multiply and divide datapaths
  always_comb begin
    start_ok  = i_Start & ~i_Flush;
    signed_op = (i_Op == OP_MULH) | (i_Op == OP_DIV) | (i_Op == OP_REM);
    div_op    = i_Op[2];
    opa       = signed_op ? abs_w(i_Op1) : i_Op1;
    opb       = signed_op ? abs_w(i_Op2) : i_Op2;

    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    prod_step = {mul_sum, prod_q[WIDTH-1:1]};

    // Trial subtraction; a borrow (negative result) means restore.
    div_sh    = {rem_q, quo_q[WIDTH-1]};
    div_trial = div_sh - {2'b00, opnd_q};
    rem_step  = div_trial[WIDTH+1] ? div_sh[WIDTH:0] : div_trial[WIDTH:0];
    quo_step  = {quo_q[WIDTH-2:0], ~div_trial[WIDTH+1]};

    prod_fix  = neg_2w(prod_q, res_neg_q);
    case (op_q)
      OP_MULH:  fix_result = prod_fix[2*WIDTH-1:WIDTH];
      OP_MULHU: fix_result = prod_q[2*WIDTH-1:WIDTH];
      OP_DIV:   fix_result = neg_w(quo_q, res_neg_q);
      OP_DIVU:  fix_result = quo_q;
      OP_REM:   fix_result = neg_w(rem_q[WIDTH-1:0], rem_neg_q);
      OP_REMU:  fix_result = rem_q[WIDTH-1:0];
      default:  fix_result = prod_q[WIDTH-1:0];
    endcase
  end

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_Start)            state_d = S_CALC;
      S_CALC: if (cnt_q == LAST_ITER) state_d = S_FIX;
      S_FIX:                          state_d = S_DONE;
      S_DONE:                         state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
    if (i_Flush) state_d = S_IDLE;
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_ok) begin
          cnt_q     <= '0;
          op_q      <= i_Op;
          opnd_q    <= div_op ? opb : opa;
          prod_q    <= {{WIDTH{1'b0}}, opb};
          rem_q     <= '0;
          quo_q     <= opa;
          // A zero divisor must yield an all-ones quotient, so never negate it.
          res_neg_q <= ((i_Op == OP_MULH) | ((i_Op == OP_DIV) & (i_Op2 != '0)))
                       & (i_Op1[WIDTH-1] ^ i_Op2[WIDTH-1]);
          rem_neg_q <= (i_Op == OP_REM) & i_Op1[WIDTH-1];
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_q[2]) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
          end else begin
            prod_q <= prod_step;
          end
        end
        S_FIX: if (!i_Flush) result_q <= fix_result;
        default: ;
      endcase
    end
  end

  assign o_Busy   = (state_q == S_CALC) | (state_q == S_FIX);
  assign o_Stall  = ((state_q == S_IDLE) & start_ok) | (state_q == S_CALC) | (state_q == S_FIX);
  assign o_Done   = (state_q == S_DONE);
  assign o_Result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and randomized bench for ex_muldiv_unit with an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] op1, op2;
  logic        busy, stall, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Op(op),
    .i_Op1(op1), .i_Op2(op2), .i_Flush(flush),
    .o_Busy(busy), .o_Stall(stall), .o_Done(done), .o_Result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Reference: results straight from integer arithmetic on 64-bit values.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    logic [63:0] w;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (o)
      3'b001: begin sp = sa * sb; w = sp; r = w[63:32]; end
      3'b010: begin up = ua * ub; w = up; r = w[63:32]; end
      3'b100: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin sp = sa / sb; w = sp; r = w[31:0]; end
      end
      3'b101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) r = a;
        else begin sp = sa % sb; w = sp; r = w[31:0]; end
      end
      3'b111: r = (b == 32'd0) ? a : a % b;
      default: begin up = ua * ub; w = up; r = w[31:0]; end
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Enter a new cycle: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation starting in the next cycle (relative cycle 0).
  // rp1/rp2 are relative cycles in which i_Start is re-pulsed while busy.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv, input int rp1, input int rp2);
    logic stall_ok;
    int   dones;
    int   done_at;
    dones   = 0;
    done_at = -1;
    tick();
    start = 1'b1; op = o; op1 = a; op2 = b;
    #1;
    stall_ok = stall;
    for (int c = 1; c <= 34; c++) begin
      tick();
      start = (c == rp1) || (c == rp2);
      op    = 3'($urandom);
      op1   = $urandom;
      op2   = $urandom;
      #1;
      if (c <= 33 && (stall !== 1'b1 || done !== 1'b0)) stall_ok = 1'b0;
      if (c >= 2 && c <= 33 && busy !== 1'b1) stall_ok = 1'b0;
      if (done === 1'b1) begin dones++; done_at = c; end
      if (c == 34) begin
        chk({tag, " result"}, result, expv);
        chk({tag, " stall_in_done"}, {31'd0, stall}, 32'd0);
        chk({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
      end
    end
    start = 1'b0;
    chk({tag, " stall_window"}, {31'd0, stall_ok}, 32'd1);
    chk({tag, " done_count"}, 32'(dones), 32'd1);
    chk({tag, " done_cycle"}, 32'(done_at), 32'd34);
    last_res = expv;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          dones;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; op1 = '0; op2 = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset busy",   {31'd0, busy},  32'd0);
    chk("reset stall",  {31'd0, stall}, 32'd0);
    chk("reset done",   {31'd0, done},  32'd0);
    chk("reset result", result,         32'd0);
    last_res = 32'd0;

    // Multiply family on 7 x -3
    do_op("MUL",   3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, -1, -1);
    do_op("MULH",  3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1, -1);
    do_op("MULHU", 3'b010, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, -1, -1);

    // Divide family
    do_op("DIV",  3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, -1, -1);
    do_op("REM",  3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, -1, -1);
    do_op("DIVU", 3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, -1, -1);
    do_op("REMU", 3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, -1, -1);

    // Divide by zero and signed overflow
    do_op("DIV0",  3'b100, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, -1, -1);
    do_op("REM0",  3'b110, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, -1, -1);
    do_op("DIVU0", 3'b101, 32'h8765_4321, 32'h0000_0000, 32'hFFFF_FFFF, -1, -1);
    do_op("REMN0", 3'b110, 32'h8765_4321, 32'h0000_0000, 32'h8765_4321, -1, -1);
    do_op("DIVOV", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1, -1);
    do_op("REMOV", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, -1, -1);
    do_op("OP011", 3'b011, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, -1, -1);

    // Flush in relative cycle 10 of a DIV
    dones = 0;
    tick();
    start = 1'b1; op = 3'b100; op1 = 32'd1000; op2 = 32'd7;
    for (int c = 1; c <= 11; c++) begin
      tick();
      start = 1'b0;
      flush = (c == 10);
      #1;
      if (done === 1'b1) dones++;
      if (c == 11) begin
        chk("flush busy",   {31'd0, busy},  32'd0);
        chk("flush stall",  {31'd0, stall}, 32'd0);
        chk("flush result", result,         last_res);
      end
    end
    chk("flush no_done", 32'(dones), 32'd0);
    // Starts in relative cycle 12, so o_Done lands in cycle 46.
    do_op("post_flush", 3'b100, 32'd1000, 32'd7, 32'd142, -1, -1);

    // Flush together with start in IDLE: nothing starts
    tick();
    start = 1'b1; flush = 1'b1; op = 3'b000; op1 = 32'd3; op2 = 32'd4;
    #1;
    chk("flush_start stall", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_start busy", {31'd0, busy}, 32'd0);

    // Ignored re-pulses of i_Start, then back-to-back accepted start
    do_op("MUL_repulse", 3'b000, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, 5, 20);
    do_op("MUL_b2b",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, -1, -1);

    // Randomized operations including corner operands
    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 16));
        default: ;
      endcase
      do_op("rand", ro, ra, rb, ref_res(ro, ra, rb), 32'($urandom_range(1, 33)), -1);
    end

    // Reset mid-operation at relative cycle 15
    tick();
    start = 1'b1; op = 3'b000; op1 = 32'd9; op2 = 32'd9;
    for (int c = 1; c <= 16; c++) begin
      tick();
      start = 1'b0;
      rst   = (c == 15);
      #1;
    end
    chk("rst_mid busy",   {31'd0, busy},  32'd0);
    chk("rst_mid stall",  {31'd0, stall}, 32'd0);
    chk("rst_mid done",   {31'd0, done},  32'd0);
    chk("rst_mid result", result,         32'd0);

    // Reset together with start: nothing starts
    tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    #1;
    chk("rst_start busy",  {31'd0, busy},  32'd0);
    chk("rst_start stall", {31'd0, stall}, 32'd0);
    last_res = 32'd0;
    do_op("after_rst", 3'b101, 32'd100, 32'd9, 32'd11, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
